// File: rtl/secondary_register_sequencer.sv
// Command sequencer feeding the ALU secondary register.
// Turns LOAD64 / LOAD_CHUNKS / ROTATE commands into a cycle-by-cycle stream
// of 2-bit control codes plus 64-bit data, and pulses done_o in the cycle the
// register already holds the finished result.
module secondary_register_sequencer #(
  parameter int CHUNKS = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [1:0]  cmd_count_i,
  input  logic [63:0] cmd_data_i,
  input  logic        chunk_valid_i,
  output logic        chunk_ready_o,
  input  logic [15:0] chunk_data_i,
  output logic [1:0]  control_o,
  output logic [63:0] data_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ISSUE      = 2'd1,
    S_CHUNK_WAIT = 2'd2,
    S_CHUNK_ROT  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD64   = 2'b00;
  localparam logic [1:0] OP_CHUNKS   = 2'b01;
  localparam logic [1:0] OP_ROTATE   = 2'b10;

  localparam logic [1:0] CTL_IDLE    = 2'b00;
  localparam logic [1:0] CTL_ROT16   = 2'b01;
  localparam logic [1:0] CTL_WR16    = 2'b10;
  localparam logic [1:0] CTL_WR64    = 2'b11;

  // Index of the final chunk; the chunk that matches it ends the stream
  // without a trailing rotate, so the first chunk lands in the top lane.
  localparam logic [2:0] LAST_CHUNK  = 3'(CHUNKS - 1);

  state_t      r_state;
  logic [1:0]  r_rem;      // rotates still to issue after the current one
  logic [2:0]  r_cnt;      // chunks consumed in this LOAD_CHUNKS
  logic [1:0]  r_control;
  logic [63:0] r_data;
  logic        r_done;

  logic w_cmd_fire;
  logic w_chunk_fire;

  // Handshake readiness is a pure function of state so it drops the moment
  // a command is taken and recovers in the done cycle.
  assign cmd_ready_o   = (r_state == S_IDLE);
  assign chunk_ready_o = (r_state == S_CHUNK_WAIT);
  assign busy_o        = (r_state != S_IDLE);
  assign w_cmd_fire    = cmd_valid_i & cmd_ready_o;
  assign w_chunk_fire  = chunk_valid_i & chunk_ready_o;

  assign control_o = r_control;
  assign data_o    = r_data;
  assign done_o    = r_done;

  // Sequencer FSM with registered control/data/done outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_rem     <= 2'd0;
      r_cnt     <= 3'd0;
      r_control <= CTL_IDLE;
      r_data    <= 64'h0;
      r_done    <= 1'b0;
    end else begin
      // Control idles and done drops unless a branch below says otherwise;
      // data_o deliberately holds between writes.
      r_control <= CTL_IDLE;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            case (cmd_op_i)
              OP_LOAD64: begin
                r_control <= CTL_WR64;
                r_data    <= cmd_data_i;
                r_rem     <= 2'd0;
                r_state   <= S_ISSUE;
              end
              OP_ROTATE: begin
                r_control <= CTL_ROT16;
                r_rem     <= cmd_count_i;
                r_state   <= S_ISSUE;
              end
              OP_CHUNKS: begin
                r_cnt     <= 3'd0;
                r_state   <= S_CHUNK_WAIT;
              end
              default: begin
                // Reserved op: behaves as a one-cycle no-op that still completes.
                r_rem     <= 2'd0;
                r_state   <= S_ISSUE;
              end
            endcase
          end
        end
        S_ISSUE: begin
          if (r_rem == 2'd0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_control <= CTL_ROT16;
            r_rem     <= r_rem - 2'd1;
          end
        end
        S_CHUNK_WAIT: begin
          if (w_chunk_fire) begin
            r_control <= CTL_WR16;
            r_data    <= {48'h0, chunk_data_i};
            r_cnt     <= r_cnt + 3'd1;
            if (r_cnt == LAST_CHUNK) begin
              r_rem   <= 2'd0;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_CHUNK_ROT;
            end
          end
        end
        S_CHUNK_ROT: begin
          // Exactly one rotate between chunks; stalls only happen in CHUNK_WAIT.
          r_control <= CTL_ROT16;
          r_state   <= S_CHUNK_WAIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/secondary_register_sequencer.md
Name: secondary_register_sequencer

Overview:
Command sequencer directly upstream of the ALU secondary register. It accepts high-level load and rotate commands and drives the register's 2-bit control and 64-bit data inputs cycle by cycle. Loads come either as one 64-bit word or as a stream of 16-bit chunks, assembled by alternating write-low-16 and rotate-left-16. It signals completion once the register holds the result.

Parameters:
CHUNKS, 4, number of 16-bit chunks per LOAD_CHUNKS command (legal 1..4). Issues CHUNKS writes and CHUNKS-1 rotates.

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n_i  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command ready; high only in IDLE (combinational from state)
cmd_op_i  input  2  00 LOAD64, 01 LOAD_CHUNKS, 10 ROTATE, 11 reserved no-op
cmd_count_i  input  2  ROTATE only: number of rotations minus 1
cmd_data_i  input  64  LOAD64 word
chunk_valid_i  input  1  chunk stream valid
chunk_ready_o  output  1  chunk stream ready; high only in CHUNK_WAIT
chunk_data_i  input  16  chunk payload, first chunk ends up most significant
control_o  output  2  to secondary register: 00 idle, 01 rotate-left-16, 10 write low 16, 11 write 64
data_o  output  64  to secondary register data input
busy_o  output  1  high whenever state != IDLE
done_o  output  1  one-cycle pulse; register holds the result in this cycle

Behaviour:
- Reset, asynchronous and active-low: state IDLE, control_o=00, data_o=0, done_o=0, chunk counter 0, rotate counter 0. Secondary register contents after a mid-command reset are undefined; the issuer must re-issue the command.
- Registered outputs: control_o, data_o and done_o are flops.
- Command handshake: accept on cmd_valid_i & cmd_ready_o at edge k.
- States: IDLE, ISSUE, CHUNK_WAIT, CHUNK_ROT.
- IDLE, on accept:
  - LOAD64: control_o<=11, data_o<=cmd_data_i, rem<=0, go ISSUE.
  - ROTATE: control_o<=01, rem<=cmd_count_i, go ISSUE.
  - reserved: control_o<=00, rem<=0, go ISSUE.
  - LOAD_CHUNKS: control_o<=00, cnt<=0, go CHUNK_WAIT.
- ISSUE, rem==0: control_o<=00, done_o<=1, go IDLE.
- ISSUE, rem!=0: control_o<=01, rem<=rem-1.
- ROTATE count 0..3 yields 1..4 consecutive 01 cycles. Four rotations restore the original value.
- CHUNK_WAIT:
  - No chunk handshake: control_o<=00.
  - Chunk handshake: control_o<=10, data_o<={48'h0, chunk_data_i}, cnt<=cnt+1.
  - Next state: if cnt==CHUNKS-1 go ISSUE with rem=0; else go CHUNK_ROT.
- CHUNK_ROT: control_o<=01, go CHUNK_WAIT. Always exactly one cycle, never stalls.
- Back-to-back chunks give the control sequence 10,01,10,01,10,01,10 (7 cycles for CHUNKS=4). Chunk gaps insert 00 cycles only after a rotate.
- Latency: LOAD64 accepted at edge k gives control_o=11 in cycle k+1 and done_o=1 in cycle k+2.
- End of command: in the done_o cycle the state is already IDLE, so cmd_ready_o=1 and a new command can be accepted in that same cycle.
- data_o changes only on writes and holds otherwise.
- chunk_valid_i outside CHUNK_WAIT is ignored; no chunk is consumed.
- cmd_valid_i while busy is ignored (cmd_ready_o=0).
- cmd_count_i is sampled only at accept.

Test Plan:
- Reset: assert rst_n_i=0 mid-LOAD_CHUNKS after 2 chunks -> control_o=00, data_o=0, done_o=0, cmd_ready_o=1 immediately (asynchronously); then issue a fresh LOAD64 -> normal completion.
- LOAD64: cmd_data_i=64'hDEADBEEFCAFEF00D accepted at edge k -> cycle k+1 control_o=11, data_o=DEADBEEFCAFEF00D; cycle k+2 done_o=1; register model equals the value.
- LOAD_CHUNKS back-to-back: chunks 0123,4567,89AB,CDEF with valid held high -> control 10,01,10,01,10,01,10 in consecutive cycles, then done_o; register model = 64'h0123456789ABCDEF regardless of prior contents.
- LOAD_CHUNKS with gaps: drop chunk_valid_i for 3 cycles before chunk 3 -> three extra 00 cycles after the second rotate; final value unchanged; chunk_ready_o never high in CHUNK_ROT.
- ROTATE: preload 64'h0123456789ABCDEF, count=0 -> exactly one 01 cycle, result 456789ABCDEF0123. Count=3 -> four 01 cycles, value restored. done_o arrives count+2 cycles after accept.
- Handshake: hold cmd_valid_i during a busy command -> no accept until the done_o cycle. Issuing a new command in the done cycle -> accepted and executed with no idle gap. Reserved op 11 -> only 00 on control_o, done_o at k+2.
